integer_issue_queue: RTL and testbench

Parametrised, collapsing integer issue queue that sits between dispatch and the integer execute pipes. It holds up to N_ENTRIES renamed micro-ops and tracks per-source readiness by snooping N_WAKEUP tag broadcast ports. Each cycle it selects the oldest fully-ready entry for issue and compacts the queue behind it. Successor to the fixed single-wakeup integer issue block: it adds configurable depth and widths, multiple wakeup ports, oldest-ready select, an occupancy count and flush.

---
 rtl/integer_issue_queue.sv | 166 ++++++++++++++++
 tb/tb_integer_issue_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/integer_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : integer_issue_queue
// Purpose  : Collapsing integer issue queue. Holds renamed micro-ops in age
//            order (slot 0 = oldest, no holes), tracks per-source readiness by
//            snooping N_WAKEUP tag broadcast ports, and each cycle offers the
//            oldest fully-ready entry to the execute pipes. Issued entries are
//            removed and younger entries shift down one slot.
// Ports    : clk, rst (sync, active high), flush (sync clear)
//            dispatch_*  : valid/ready entry write port with source tags,
//                          source-ready flags, destination tag and payload
//            wakeup_*    : N_WAKEUP tag broadcasts, port k at [k*TAG_W +: TAG_W]
//            issue_*     : valid/ready selected entry (payload, dst tag)
//            count       : number of valid entries
// Revision : 1.0 - initial release
// ============================================================================
module integer_issue_queue #(
  parameter int N_ENTRIES = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64,
  parameter int N_WAKEUP  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            dispatch_valid,
  output logic                            dispatch_ready,
  input  logic [PAYLOAD_W-1:0]            dispatch_payload,
  input  logic [TAG_W-1:0]                dispatch_src1_tag,
  input  logic [TAG_W-1:0]                dispatch_src2_tag,
  input  logic                            dispatch_src1_rdy,
  input  logic                            dispatch_src2_rdy,
  input  logic [TAG_W-1:0]                dispatch_dst_tag,
  input  logic [N_WAKEUP-1:0]             wakeup_valid,
  input  logic [N_WAKEUP*TAG_W-1:0]       wakeup_tag,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [PAYLOAD_W-1:0]            issue_payload,
  output logic [TAG_W-1:0]                issue_dst_tag,
  output logic [$clog2(N_ENTRIES+1)-1:0]  count
);

  localparam int CNT_W = $clog2(N_ENTRIES + 1);
  localparam int IDX_W = $clog2(N_ENTRIES);

  // Slot storage
  logic [PAYLOAD_W-1:0] payload_q  [N_ENTRIES];
  logic [PAYLOAD_W-1:0] payload_d  [N_ENTRIES];
  logic [TAG_W-1:0]     dst_tag_q  [N_ENTRIES];
  logic [TAG_W-1:0]     dst_tag_d  [N_ENTRIES];
  logic [TAG_W-1:0]     src1_tag_q [N_ENTRIES];
  logic [TAG_W-1:0]     src1_tag_d [N_ENTRIES];
  logic [TAG_W-1:0]     src2_tag_q [N_ENTRIES];
  logic [TAG_W-1:0]     src2_tag_d [N_ENTRIES];
  logic [N_ENTRIES-1:0] src1_rdy_q, src1_rdy_d;
  logic [N_ENTRIES-1:0] src2_rdy_q, src2_rdy_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [N_ENTRIES-1:0] eligible;
  logic [IDX_W-1:0]     sel_idx;
  logic                 any_eligible;
  logic                 dispatch_fire;
  logic                 issue_fire;
  logic [CNT_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     src_idx;
  logic                 disp_src1_rdy;
  logic                 disp_src2_rdy;

  // True when any valid broadcast port carries the given tag.
  function automatic logic wake_hit(
    input logic [TAG_W-1:0]          tag,
    input logic [N_WAKEUP-1:0]       vld,
    input logic [N_WAKEUP*TAG_W-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N_WAKEUP; k++) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Slots at or above count are empty; their ready bits are ignored here.
  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_elig
    assign eligible[i] = (CNT_W'(i) < count_q) & src1_rdy_q[i] & src2_rdy_q[i];
  end

  // Oldest-first select: scan from the top so the lowest index is written last.
  always_comb begin
    sel_idx      = '0;
    any_eligible = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_idx      = IDX_W'(i);
        any_eligible = 1'b1;
      end
    end
  end

  assign dispatch_ready = (count_q != CNT_W'(N_ENTRIES));
  assign dispatch_fire  = dispatch_valid & dispatch_ready;
  assign issue_valid    = any_eligible;
  assign issue_fire     = any_eligible & issue_ready;
  assign issue_payload  = payload_q[sel_idx];
  assign issue_dst_tag  = dst_tag_q[sel_idx];
  assign count          = count_q;

  // A dispatching source also catches a broadcast seen in the same cycle.
  assign disp_src1_rdy = dispatch_src1_rdy | wake_hit(dispatch_src1_tag, wakeup_valid, wakeup_tag);
  assign disp_src2_rdy = dispatch_src2_rdy | wake_hit(dispatch_src2_tag, wakeup_valid, wakeup_tag);

  // Next state: collapse over the issued slot, then apply wakeups to the
  // entries at their new positions, then drop the dispatched entry on top.
  always_comb begin
    count_d    = count_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
    wr_idx     = count_q - CNT_W'(issue_fire);
    src_idx    = '0;
    src1_rdy_d = '0;
    src2_rdy_d = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      src_idx = IDX_W'(i);
      if (issue_fire && (i >= int'(sel_idx)) && (i < N_ENTRIES - 1)) begin
        src_idx = IDX_W'(i + 1);
      end
      payload_d[i]  = payload_q[src_idx];
      dst_tag_d[i]  = dst_tag_q[src_idx];
      src1_tag_d[i] = src1_tag_q[src_idx];
      src2_tag_d[i] = src2_tag_q[src_idx];
      src1_rdy_d[i] = src1_rdy_q[src_idx] | wake_hit(src1_tag_q[src_idx], wakeup_valid, wakeup_tag);
      src2_rdy_d[i] = src2_rdy_q[src_idx] | wake_hit(src2_tag_q[src_idx], wakeup_valid, wakeup_tag);
      if (dispatch_fire && (wr_idx == CNT_W'(i))) begin
        payload_d[i]  = dispatch_payload;
        dst_tag_d[i]  = dispatch_dst_tag;
        src1_tag_d[i] = dispatch_src1_tag;
        src2_tag_d[i] = dispatch_src2_tag;
        src1_rdy_d[i] = disp_src1_rdy;
        src2_rdy_d[i] = disp_src2_rdy;
      end
    end
  end

  // Control state: flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
    end else begin
      count_q    <= count_d;
      src1_rdy_q <= src1_rdy_d;
      src2_rdy_q <= src2_rdy_d;
    end
  end

  // Data state needs no reset: validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      payload_q[i]  <= payload_d[i];
      dst_tag_q[i]  <= dst_tag_d[i];
      src1_tag_q[i] <= src1_tag_d[i];
      src2_tag_q[i] <= src2_tag_d[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_integer_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_integer_issue_queue
// Purpose  : Self-checking bench for integer_issue_queue. A table of directed
//            per-cycle vectors (inputs plus expected outputs for that cycle)
//            followed by short hand-written multi-cycle sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_integer_issue_queue;

  localparam int N_ENTRIES = 8;
  localparam int TAG_W     = 6;
  localparam int PAYLOAD_W = 64;
  localparam int N_WAKEUP  = 2;
  localparam int CNT_W     = $clog2(N_ENTRIES + 1);

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic                       dispatch_valid;
  logic                       dispatch_ready;
  logic [PAYLOAD_W-1:0]       dispatch_payload;
  logic [TAG_W-1:0]           dispatch_src1_tag;
  logic [TAG_W-1:0]           dispatch_src2_tag;
  logic                       dispatch_src1_rdy;
  logic                       dispatch_src2_rdy;
  logic [TAG_W-1:0]           dispatch_dst_tag;
  logic [N_WAKEUP-1:0]        wakeup_valid;
  logic [N_WAKEUP*TAG_W-1:0]  wakeup_tag;
  logic                       issue_valid;
  logic                       issue_ready;
  logic [PAYLOAD_W-1:0]       issue_payload;
  logic [TAG_W-1:0]           issue_dst_tag;
  logic [CNT_W-1:0]           count;

  integer_issue_queue #(
    .N_ENTRIES (N_ENTRIES),
    .TAG_W     (TAG_W),
    .PAYLOAD_W (PAYLOAD_W),
    .N_WAKEUP  (N_WAKEUP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .dispatch_valid    (dispatch_valid),
    .dispatch_ready    (dispatch_ready),
    .dispatch_payload  (dispatch_payload),
    .dispatch_src1_tag (dispatch_src1_tag),
    .dispatch_src2_tag (dispatch_src2_tag),
    .dispatch_src1_rdy (dispatch_src1_rdy),
    .dispatch_src2_rdy (dispatch_src2_rdy),
    .dispatch_dst_tag  (dispatch_dst_tag),
    .wakeup_valid      (wakeup_valid),
    .wakeup_tag        (wakeup_tag),
    .issue_valid       (issue_valid),
    .issue_ready       (issue_ready),
    .issue_payload     (issue_payload),
    .issue_dst_tag     (issue_dst_tag),
    .count             (count)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected during that cycle
  // (before the edge that consumes the stimulus). e_dst < 0: don't check.
  typedef struct {
    bit       rst, flush, dv;
    int       dst, s1, s2;
    bit       r1, r2;
    bit [1:0] wv;
    int       wt0, wt1;
    bit       ir;
    bit       e_drdy, e_ivld;
    int       e_dst, e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [63:0] pay(input int dst);
    return 64'hC0DE_0000_0000_0000 | 64'(dst);
  endfunction

  function automatic vec_t mk(
    input bit rst_, flush_, dv_, input int dst_, s1_, input bit r1_,
    input int s2_, input bit r2_, input bit [1:0] wv_, input int wt0_, wt1_,
    input bit ir_, e_drdy_, e_ivld_, input int e_dst_, e_cnt_);
    vec_t v;
    v.rst = rst_; v.flush = flush_; v.dv = dv_; v.dst = dst_;
    v.s1 = s1_; v.r1 = r1_; v.s2 = s2_; v.r2 = r2_;
    v.wv = wv_; v.wt0 = wt0_; v.wt1 = wt1_; v.ir = ir_;
    v.e_drdy = e_drdy_; v.e_ivld = e_ivld_; v.e_dst = e_dst_; v.e_cnt = e_cnt_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst               = v.rst;
    flush             = v.flush;
    dispatch_valid    = v.dv;
    dispatch_dst_tag  = TAG_W'(v.dst);
    dispatch_payload  = pay(v.dst);
    dispatch_src1_tag = TAG_W'(v.s1);
    dispatch_src2_tag = TAG_W'(v.s2);
    dispatch_src1_rdy = v.r1;
    dispatch_src2_rdy = v.r2;
    wakeup_valid      = v.wv;
    wakeup_tag        = {TAG_W'(v.wt1), TAG_W'(v.wt0)};
    issue_ready       = v.ir;
  endtask

  // Drive just after the rising edge, check at the falling edge, then advance.
  task automatic run(input string tag, input vec_t v);
    #1;
    drive(v);
    @(negedge clk);
    chk({tag, " count"}, 64'(count), 64'(v.e_cnt));
    chk({tag, " dispatch_ready"}, 64'(dispatch_ready), 64'(v.e_drdy));
    chk({tag, " issue_valid"}, 64'(issue_valid), 64'(v.e_ivld));
    if (v.e_dst >= 0) begin
      chk({tag, " issue_dst_tag"}, 64'(issue_dst_tag), 64'(v.e_dst));
      chk({tag, " issue_payload"}, issue_payload, pay(v.e_dst));
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Fill: eight ready entries, nothing issued; 9th offer refused.
    //               rst fl dv dst s1 r1 s2 r2 wv  wt0 wt1 ir drdy ivld dst cnt
    vecs.push_back(mk(1, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 0, 1,   0,  -1, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 0, 1, k, 0, 1, 0, 1, 0, 0, 0, 0, 1, k > 1, k > 1 ? 1 : -1, k - 1));
    vecs.push_back(mk(0, 0, 1,  9, 0, 1, 0, 1, 0,  0,  0, 0, 0,   1,   1, 8));
    // Full with simultaneous issue: dispatch refused, count drops to 7.
    vecs.push_back(mk(0, 0, 1, 10, 0, 1, 0, 1, 0,  0,  0, 1, 0,   1,   1, 8));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 0, 1,   1,   2, 7));
    // Drain in dispatch order; 9 and 10 never appear.
    for (int k = 2; k <= 8; k++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, k, 9 - k));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 1, 1,   0,  -1, 0));
    // Wakeup ordering: A waits on tag 5, B overtakes; wakeup on port 1.
    vecs.push_back(mk(0, 0, 1, 20, 5, 0, 0, 1, 0,  0,  0, 1, 1,   0,  -1, 0));
    vecs.push_back(mk(0, 0, 1, 21, 0, 1, 0, 1, 0,  0,  0, 1, 1,   0,  -1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 1, 1,   1,  21, 2));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 2,  0,  5, 1, 1,   0,  -1, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 1, 1,   1,  20, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 1, 1,   0,  -1, 0));
    // Same-cycle wakeup on dispatch of src2 tag 12.
    vecs.push_back(mk(0, 0, 1, 26, 3, 1,12, 0, 1, 12,  0, 1, 1,   0,  -1, 0));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 1, 1,   1,  26, 1));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 1, 1,   0,  -1, 0));
    // Collapse: E0..E3 (30..33), only E2 ready; issue E2 while E4 dispatches.
    vecs.push_back(mk(0, 0, 1, 30,40, 0, 0, 1, 0,  0,  0, 0, 1,   0,  -1, 0));
    vecs.push_back(mk(0, 0, 1, 31,41, 0, 0, 1, 0,  0,  0, 0, 1,   0,  -1, 1));
    vecs.push_back(mk(0, 0, 1, 32, 0, 1, 0, 1, 0,  0,  0, 0, 1,   0,  -1, 2));
    vecs.push_back(mk(0, 0, 1, 33,43, 0, 0, 1, 0,  0,  0, 0, 1,   1,  32, 3));
    vecs.push_back(mk(0, 0, 1, 34,44, 0, 0, 1, 0,  0,  0, 1, 1,   1,  32, 4));
    // Wake E3 and E4; E3 must win as the older one (E0, E1, E3, E4).
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 3, 43, 44, 0, 1,   0,  -1, 4));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 0, 1,   1,  33, 4));
    // Issue E3 while waking E1, which keeps its slot.
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 1, 41,  0, 1, 1,   1,  33, 4));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 1, 1,   1,  31, 3));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 1, 1,   1,  34, 2));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 1, 1,   0,  -1, 1));
    // Flush at count 5 with dispatch and a wakeup of E0 in the same cycle.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 0, 1, 50 + k, 0, 1, 0, 1, 0, 0, 0, 0, 1, k > 0, k > 0 ? 50 : -1, k + 1));
    vecs.push_back(mk(0, 1, 1, 54, 0, 1, 0, 1, 1, 40,  0, 0, 1,   1,  50, 5));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 0, 1,   0,  -1, 0));
    // Reset mid-stream.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 0, 1, 60 + k, 0, 1, 0, 1, 0, 0, 0, 0, 1, k > 0, k > 0 ? 60 : -1, k));
    vecs.push_back(mk(1, 0, 1, 63, 0, 1, 0, 1, 3,  1,  2, 1, 1,   1,  60, 3));
    vecs.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1, 0,  0,  0, 0, 1,   0,  -1, 0));

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0));
    repeat (2) @(posedge clk);

    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back dispatch and issue: each entry issues the cycle after it lands.
    for (int k = 0; k < 5; k++)
      run($sformatf("stream%0d", k),
          mk(0, 0, 1, 10 + k, 0, 1, 0, 1, 0, 0, 0, 1, 1, k > 0, k > 0 ? 9 + k : -1, k > 0 ? 1 : 0));
    run("stream_tail", mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 14, 1));
    run("stream_empty", mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, -1, 0));

    // Duplicate wakeup on both ports for src1 must not ready src2.
    run("dup0", mk(0, 0, 1, 45, 7, 0, 8, 0, 0, 0, 0, 1, 1, 0, -1, 0));
    run("dup1", mk(0, 0, 0,  0, 0, 1, 0, 1, 3, 7, 7, 1, 1, 0, -1, 1));
    run("dup2", mk(0, 0, 0,  0, 0, 1, 0, 1, 2, 0, 8, 1, 1, 0, -1, 1));
    run("dup3", mk(0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 45, 1));
    run("dup4", mk(0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, -1, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
